// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer
//   Upstream driver for a 1-to-N demultiplexer. It accepts one N-bit word over
//   a valid/ready handshake. It then steps the demux select through the
//   channels and holds each channel for DWELL clocks. While the select equals i,
//   the data line carries bit i of the accepted word.
//
//   Optional build macro: DEMUX_SCAN_SKIP_ZERO_EN
//     When defined, only channels whose latched bit is 1 are visited, in
//     ascending order, and D is 1 throughout the scan. An all-zero word goes
//     straight to DONE.
//
// Parameters
//   SEL_W : select width; channel count N = 2**SEL_W
//   DWELL : clocks per channel slot, 1..255
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst      : synchronous active-high reset
//   in_valid : upstream word available
//   in_ready : word can be accepted this cycle (registered)
//   in_data  : word to scan out; bit i goes to channel i
//   D        : demux data line (registered)
//   S        : demux select (registered)
//   busy     : high while a word is being scanned
//   done     : one-cycle pulse after the last channel slot
module demux_scan_sequencer #(
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(1<<SEL_W)-1:0]  in_data,
  output logic                   D,
  output logic [SEL_W-1:0]       S,
  output logic                   busy,
  output logic                   done
);

  localparam int N = 1 << SEL_W;
  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("demux_scan_sequencer: DWELL must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q;
  logic [7:0]     cnt_q;
  // Normal build: the bits still to be presented, shifted so that bit 0 is next.
  // Skip build: the set bits still to visit.
  logic [N-1:0]   sh_q;
  logic           slot_end_d;

  assign slot_end_d = (cnt_q == DWELL_M1);

`ifdef DEMUX_SCAN_SKIP_ZERO_EN
  localparam logic [N-1:0] ONE = 1;

  // Index of the lowest set bit. The caller guarantees that v is non-zero.
  function automatic logic [SEL_W-1:0] lsb_idx(input logic [N-1:0] v);
    lsb_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lsb_idx = SEL_W'(i);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      D        <= 1'b0;
      S        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q    <= '0;
            in_ready <= 1'b0;
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
            if (in_data == '0) begin
              // Nothing to visit, so skip SCAN entirely.
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= SCAN;
              busy    <= 1'b1;
              D       <= 1'b1;
              S       <= lsb_idx(in_data);
              sh_q    <= in_data & (in_data - ONE);  // drop the bit being shown
            end
`else
            state_q <= SCAN;
            busy    <= 1'b1;
            S       <= '0;
            D       <= in_data[0];
            sh_q    <= in_data >> 1;
`endif
          end
        end

        SCAN: begin
          if (slot_end_d) begin
            cnt_q <= '0;
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
            if (sh_q == '0) begin
`else
            if (&S) begin
`endif
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              D       <= 1'b0;
              S       <= '0;
            end else begin
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
              S    <= lsb_idx(sh_q);
              sh_q <= sh_q & (sh_q - ONE);
`else
              S    <= S + 1'b1;
              D    <= sh_q[0];
              sh_q <= sh_q >> 1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DONE: begin
          state_q  <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end

        default: begin
          state_q  <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
          D        <= 1'b0;
          S        <= '0;
        end
      endcase
    end
  end

endmodule
